id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection, bubble insertion and branch flush.
- Captures decoded control, operands and register specifiers from ID and presents them to EX, the forwarding unit and the ALU muxes.
- Drives the PC/IF-ID write enables.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32, width of data path, PC and immediate.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- id_wb  input  2  WB control: [1] RegWrite, [0] MemtoReg
- id_m  input  3  MEM control: [2] Branch, [1] MemRead, [0] MemWrite
- id_ex  input  4  EX control: [3] RegDst, [2:1] ALUOp, [0] ALUSrc
- id_pc_plus4  input  DATA_W  PC+4 of the ID instruction
- id_rdata1  input  DATA_W  register file port 1 (rs)
- id_rdata2  input  DATA_W  register file port 2 (rt)
- id_imm  input  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  input  5 each  register specifiers
- flush  input  1  branch taken, resolved in MEM; kill the ID instruction
- ex_wb  output  2  registered WB control
- ex_m  output  3  registered MEM control
- ex_ctl  output  4  registered EX control
- ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm  output  DATA_W each  registered data
- ex_rs, ex_rt, ex_rd  output  5 each  registered specifiers, to the forwarding unit and the dest mux
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID register enable
- stall_cnt  output  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_n low, asynchronous): every registered output and stall_cnt go to 0. pc_write and if_id_write read 1 while in reset, because no stall is possible with zero ex_m.
- Load-use detect (combinational): stall = ex_m[1] && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt).
- pc_write = if_id_write = !stall || flush. Flush overrides the stall so the branch redirect proceeds.
- Each rising edge, when not in reset:
  - bubble = stall || flush.
  - If bubble: ex_wb, ex_m and ex_ctl load 0. Data and specifier fields load the ID values normally; they are don't-care but deterministic, and a bubble must never write or access memory.
  - Else: all fields load their id_* inputs.
- Latency: exactly one cycle from ID inputs to ex_* outputs. No hold state, because a stall is a bubble insert, not a freeze of ID/EX.
- A stall lasts exactly one cycle per load-use pair. The next cycle's ex_m carries the bubble (MemRead=0), so stall deasserts automatically and the held instruction proceeds. Back-to-back loads with dependents produce one stall each.
- stall_cnt increments on each clock edge where stall && !flush. It saturates at all-ones with no wrap. It clears only on reset.
- Simultaneous stall and flush: flush wins. The bubble is inserted, the counter is not incremented, and pc_write=1.
- Reset asserted mid-stall: outputs clear immediately. After release no stall is pending.
- Register $0: a load targeting rt=0 never stalls.

Decomposition:
- Shared package mips_pipe_pkg:
  - WB/M/EX field widths.
  - Bit-index constants (WB_REGWRITE=1, WB_MEMTOREG=0, M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0, EX_REGDST=3, EX_ALUSRC=0).
  - REG_ZERO=5'd0.
- One sub-module: load_use_detect. It is combinational, with inputs ex_memread, ex_rt, id_rs and id_rt, and output stall. It is reusable by a later branch-in-ID hazard unit.
- The register and counter stay in id_ex_stage_reg.

Test Plan:
- Reset: drive all id_* to nonzero values with rst_n=0 -> every ex_* = 0, stall_cnt=0, pc_write=1; release rst_n, first edge -> ex_* equal id_*.
- Plain pass-through: id_wb=2'b10, id_ex=4'b1100, id_rs=8, id_rt=9, id_rd=10, id_rdata1=32'h1234 -> next edge ex_wb=2'b10, ex_rd=10, ex_rdata1=32'h1234; pc_write=1 throughout.
- Load-use: first cycle loads lw with id_m=3'b010, id_rt=5; next cycle id_rs=5 -> stall=1, pc_write=if_id_write=0, next edge ex_wb=ex_m=ex_ctl=0, stall_cnt=1; the following cycle stall=0 and the dependent instruction lands in EX.
- Load to $0: lw with rt=0 followed by an instruction with rs=0 -> no stall, stall_cnt unchanged.
- Flush with stall: same load-use setup plus flush=1 -> pc_write=1, a bubble is inserted, stall_cnt is not incremented.
- Saturation: with CNT_W=4, force 17 stall cycles -> stall_cnt holds 4'hF.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pipe_pkg
// Description : Shared field widths, control-bit indices and register
//               constants for the 5-stage MIPS pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    // Control bundle widths carried through the pipeline
    localparam int WB_W  = 2;
    localparam int M_W   = 3;
    localparam int EX_W  = 4;
    localparam int REG_W = 5;

    // WB control bits
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // MEM control bits
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;

    // EX control bits (ALUOp occupies [2:1])
    localparam int EX_REGDST = 3;
    localparam int EX_ALUSRC = 0;

    // Hard-wired zero register
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/id_ex_stage_reg_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detector. Flags a stall when
//               the instruction in EX is a load whose destination (rt) is a
//               source of the instruction in ID. Loads to $0 never stall.
// Ports       : ex_memread - MemRead of the instruction in EX
//               ex_rt      - load destination register in EX
//               id_rs      - ID source register rs
//               id_rt      - ID source register rt
//               stall      - hazard present, insert one bubble
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import mips_pipe_pkg::*;
(
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             stall
);

    logic w_rt_nonzero;
    logic w_src_match;

    assign w_rt_nonzero = (ex_rt != REG_ZERO);
    assign w_src_match  = (ex_rt == id_rs) || (ex_rt == id_rt);
    assign stall        = ex_memread && w_rt_nonzero && w_src_match;

endmodule : load_use_detect
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register with load-use hazard detection,
//               bubble insertion on stall or branch flush, PC/IF-ID write
//               enables and a saturating stall-cycle counter.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               id_wb/id_m/id_ex           - decoded control from ID
//               id_pc_plus4, id_rdata1/2,
//               id_imm, id_rs/rt/rd        - operands and specifiers from ID
//               flush                      - branch taken, kill ID instruction
//               ex_*                       - registered copies presented to EX
//               pc_write, if_id_write      - front-end enables (low on stall)
//               stall_cnt                  - saturating load-use stall count
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WB_W-1:0]   id_wb,
    input  logic [M_W-1:0]    id_m,
    input  logic [EX_W-1:0]   id_ex,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              flush,
    output logic [WB_W-1:0]   ex_wb,
    output logic [M_W-1:0]    ex_m,
    output logic [EX_W-1:0]   ex_ctl,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WB_W-1:0]   r_ex_wb;
    logic [M_W-1:0]    r_ex_m;
    logic [EX_W-1:0]   r_ex_ctl;
    logic [DATA_W-1:0] r_ex_pc_plus4;
    logic [DATA_W-1:0] r_ex_rdata1;
    logic [DATA_W-1:0] r_ex_rdata2;
    logic [DATA_W-1:0] r_ex_imm;
    logic [REG_W-1:0]  r_ex_rs;
    logic [REG_W-1:0]  r_ex_rt;
    logic [REG_W-1:0]  r_ex_rd;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_stall;
    logic w_bubble;
    logic w_front_en;

    // Hazard check compares the load now in EX against the operands in ID
    load_use_detect u_load_use_detect (
        .ex_memread (r_ex_m[M_MEMREAD]),
        .ex_rt      (r_ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .stall      (w_stall)
    );

    // Flush overrides the stall so the branch redirect is not blocked
    assign w_front_en = !w_stall || flush;
    assign w_bubble   = w_stall || flush;

    // Control is zeroed on a bubble so it can never write or touch memory;
    // data and specifiers still load to stay deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_wb       <= '0;
            r_ex_m        <= '0;
            r_ex_ctl      <= '0;
            r_ex_pc_plus4 <= '0;
            r_ex_rdata1   <= '0;
            r_ex_rdata2   <= '0;
            r_ex_imm      <= '0;
            r_ex_rs       <= '0;
            r_ex_rt       <= '0;
            r_ex_rd       <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_wb  <= '0;
                r_ex_m   <= '0;
                r_ex_ctl <= '0;
            end else begin
                r_ex_wb  <= id_wb;
                r_ex_m   <= id_m;
                r_ex_ctl <= id_ex;
            end
            r_ex_pc_plus4 <= id_pc_plus4;
            r_ex_rdata1   <= id_rdata1;
            r_ex_rdata2   <= id_rdata2;
            r_ex_imm      <= id_imm;
            r_ex_rs       <= id_rs;
            r_ex_rt       <= id_rt;
            r_ex_rd       <= id_rd;
        end
    end

    // Counts only stalls that actually hold the front end; saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !flush && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign ex_wb       = r_ex_wb;
    assign ex_m        = r_ex_m;
    assign ex_ctl      = r_ex_ctl;
    assign ex_pc_plus4 = r_ex_pc_plus4;
    assign ex_rdata1   = r_ex_rdata1;
    assign ex_rdata2   = r_ex_rdata2;
    assign ex_imm      = r_ex_imm;
    assign ex_rs       = r_ex_rs;
    assign ex_rt       = r_ex_rt;
    assign ex_rd       = r_ex_rd;
    assign pc_write    = w_front_en;
    assign if_id_write = w_front_en;
    assign stall_cnt   = r_stall_cnt;

endmodule : id_ex_stage_reg
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_reg
// Description : Directed self-checking bench for id_ex_stage_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic [1:0]        id_wb;
    logic [2:0]        id_m;
    logic [3:0]        id_ex;
    logic [DATA_W-1:0] id_pc_plus4, id_rdata1, id_rdata2, id_imm;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              flush;
    logic [1:0]        ex_wb;
    logic [2:0]        ex_m;
    logic [3:0]        ex_ctl;
    logic [DATA_W-1:0] ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic              pc_write, if_id_write;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_wb       (id_wb),
        .id_m        (id_m),
        .id_ex       (id_ex),
        .id_pc_plus4 (id_pc_plus4),
        .id_rdata1   (id_rdata1),
        .id_rdata2   (id_rdata2),
        .id_imm      (id_imm),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .flush       (flush),
        .ex_wb       (ex_wb),
        .ex_m        (ex_m),
        .ex_ctl      (ex_ctl),
        .ex_pc_plus4 (ex_pc_plus4),
        .ex_rdata1   (ex_rdata1),
        .ex_rdata2   (ex_rdata2),
        .ex_imm      (ex_imm),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_rd       (ex_rd),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset with nonzero inputs ----------------
        rst_n = 1'b0; flush = 1'b0;
        id_wb = 2'b11; id_m = 3'b101; id_ex = 4'b1011;
        id_pc_plus4 = 32'h0000_0100; id_rdata1 = 32'h0000_AAAA;
        id_rdata2 = 32'h0000_BBBB; id_imm = 32'h0000_CCCC;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
        tick(); tick();
        check("rst_ex_wb",   32'(ex_wb), 32'd0);
        check("rst_ex_m",    32'(ex_m), 32'd0);
        check("rst_ex_ctl",  32'(ex_ctl), 32'd0);
        check("rst_rdata1",  ex_rdata1, 32'd0);
        check("rst_ex_rd",   32'(ex_rd), 32'd0);
        check("rst_cnt",     32'(stall_cnt), 32'd0);
        check("rst_pc_wr",   32'(pc_write), 32'd1);
        check("rst_ifid_wr", 32'(if_id_write), 32'd1);

        // First edge after release captures ID inputs
        rst_n = 1'b1;
        tick();
        check("rel_ex_wb",  32'(ex_wb), 32'd3);
        check("rel_ex_m",   32'(ex_m), 32'd5);
        check("rel_ex_ctl", 32'(ex_ctl), 32'hB);
        check("rel_pc4",    ex_pc_plus4, 32'h100);
        check("rel_rdata2", ex_rdata2, 32'hBBBB);
        check("rel_imm",    ex_imm, 32'hCCCC);
        check("rel_rs",     32'(ex_rs), 32'd1);
        check("rel_rt",     32'(ex_rt), 32'd2);

        // ---------------- plain pass-through ----------------
        id_wb = 2'b10; id_m = 3'b000; id_ex = 4'b1100;
        id_rs = 5'd8; id_rt = 5'd9; id_rd = 5'd10; id_rdata1 = 32'h1234;
        #1;
        check("pt_pc_wr_pre", 32'(pc_write), 32'd1);
        tick();
        check("pt_ex_wb",   32'(ex_wb), 32'd2);
        check("pt_ex_ctl",  32'(ex_ctl), 32'hC);
        check("pt_ex_rd",   32'(ex_rd), 32'd10);
        check("pt_rdata1",  ex_rdata1, 32'h1234);
        check("pt_pc_wr",   32'(pc_write), 32'd1);

        // ---------------- load-use ----------------
        id_wb = 2'b11; id_m = 3'b010; id_ex = 4'b0011;
        id_rs = 5'd8; id_rt = 5'd5; id_rd = 5'd0;
        tick();
        check("lu_load_m",  32'(ex_m), 32'd2);
        id_wb = 2'b10; id_m = 3'b000; id_ex = 4'b1100;
        id_rs = 5'd5; id_rt = 5'd6; id_rd = 5'd7;
        #1;
        check("lu_pc_wr",   32'(pc_write), 32'd0);
        check("lu_ifid_wr", 32'(if_id_write), 32'd0);
        tick();
        check("lu_bub_wb",  32'(ex_wb), 32'd0);
        check("lu_bub_m",   32'(ex_m), 32'd0);
        check("lu_bub_ctl", 32'(ex_ctl), 32'd0);
        check("lu_cnt",     32'(stall_cnt), 32'd1);
        check("lu_release", 32'(pc_write), 32'd1);
        tick();
        check("lu_dep_wb",  32'(ex_wb), 32'd2);
        check("lu_dep_ctl", 32'(ex_ctl), 32'hC);
        check("lu_dep_rd",  32'(ex_rd), 32'd7);
        check("lu_cnt2",    32'(stall_cnt), 32'd1);

        // ---------------- load to $0 ----------------
        id_wb = 2'b11; id_m = 3'b010; id_ex = 4'b0011;
        id_rs = 5'd3; id_rt = 5'd0; id_rd = 5'd0;
        tick();
        id_wb = 2'b10; id_m = 3'b000; id_ex = 4'b1100;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd4;
        #1;
        check("z_pc_wr",  32'(pc_write), 32'd1);
        tick();
        check("z_ex_wb",  32'(ex_wb), 32'd2);
        check("z_cnt",    32'(stall_cnt), 32'd1);

        // ---------------- load-use match on rt, with flush ----------------
        id_wb = 2'b11; id_m = 3'b010; id_ex = 4'b0011;
        id_rs = 5'd1; id_rt = 5'd5; id_rd = 5'd0;
        tick();
        id_wb = 2'b11; id_m = 3'b001; id_ex = 4'b1001;
        id_rs = 5'd2; id_rt = 5'd5; id_rd = 5'd9;
        flush = 1'b1;
        #1;
        check("fl_pc_wr",   32'(pc_write), 32'd1);
        check("fl_ifid_wr", 32'(if_id_write), 32'd1);
        tick();
        flush = 1'b0;
        check("fl_bub_wb",  32'(ex_wb), 32'd0);
        check("fl_bub_m",   32'(ex_m), 32'd0);
        check("fl_bub_ctl", 32'(ex_ctl), 32'd0);
        check("fl_cnt",     32'(stall_cnt), 32'd1);

        // Stall via rt match alone (no flush) counts
        id_m = 3'b010; id_rs = 5'd1; id_rt = 5'd6;
        tick();
        id_m = 3'b000; id_rs = 5'd2; id_rt = 5'd6;
        #1;
        check("rt_pc_wr", 32'(pc_write), 32'd0);
        tick();
        check("rt_cnt",   32'(stall_cnt), 32'd2);

        // ---------------- saturation ----------------
        for (int i = 1; i <= 17; i++) begin
            id_wb = 2'b11; id_m = 3'b010; id_rs = 5'd1; id_rt = 5'd5;
            tick();
            id_m = 3'b000; id_rs = 5'd5; id_rt = 5'd6;
            tick();
            check($sformatf("sat_%0d", i), 32'(stall_cnt), (2 + i > 15) ? 32'd15 : 32'(2 + i));
        end

        // ---------------- reset mid-stall ----------------
        id_m = 3'b010; id_rs = 5'd1; id_rt = 5'd5;
        tick();
        id_m = 3'b000; id_rs = 5'd5; id_rt = 5'd6;
        #1;
        check("ms_stalled", 32'(pc_write), 32'd0);
        rst_n = 1'b0;
        #1;
        check("ms_ex_m",   32'(ex_m), 32'd0);
        check("ms_ex_rt",  32'(ex_rt), 32'd0);
        check("ms_cnt",    32'(stall_cnt), 32'd0);
        check("ms_pc_wr",  32'(pc_write), 32'd1);
        tick();
        rst_n = 1'b1;
        #1;
        check("ms_rel_pc_wr", 32'(pc_write), 32'd1);
        tick();
        check("ms_rel_wb",  32'(ex_wb), 32'd3);
        check("ms_rel_cnt", 32'(stall_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_id_ex_stage_reg
`default_nettype wire
